// File: rtl/uart_pkg.sv
// Shared definitions for the 32-bit UART link: frame geometry and receiver states.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 32;
  localparam int UART_MID_TICK   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Flop chain that brings the asynchronous serial line into the clk domain.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Reset to 1 so a reset never looks like a start bit on an idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_32_bit_rx.sv
// 16x-oversampled receiver for 1 start, 32 data (LSB first), 1 stop bit frames.
// Handshake: valid is a one-cycle strobe with no ready; data holds until the next good frame.
module uart_32_bit_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(UART_MID_TICK);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_rx_state_t       state, state_next;
  logic [TW-1:0]        tick_cnt, tick_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic [DATA_BITS-1:0] data_q, data_next;
  logic                 valid_q, valid_next;
  logic                 ferr_q, ferr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
      shift_q  <= shift_next;
      data_q   <= data_next;
      valid_q  <= valid_next;
      ferr_q   <= ferr_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_q;
    data_next  = data_q;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      IDLE: begin
        if (baud_tick && !rx_s) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_MID) begin
            // A line that has returned high by mid start bit was a glitch.
            if (!rx_s) begin
              state_next = DATA;
              tick_next  = '0;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            shift_next = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_next  = '0;
            if (bit_cnt == BIT_LAST) begin
              state_next = STOP;
            end else begin
              bit_next = bit_cnt + 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            // Returning at mid stop bit leaves half a bit to catch the next start edge.
            state_next = IDLE;
            if (rx_s) begin
              data_next  = shift_q;
              valid_next = 1'b1;
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_32_bit_rx.sv
// Directed bench for uart_32_bit_rx: bit-accurate serial frames against hand-computed words.
module tb_uart_32_bit_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        baud_tick = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] data;
  logic        valid;
  logic        frame_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / tick generation
  always #5 clk = ~clk;

  logic       tick_en = 1'b0;
  logic [1:0] div = 2'd0;
  int         tb_ticks = 0;

  always @(posedge clk) begin
    if (tick_en) begin
      div       <= div + 2'd1;
      baud_tick <= (div == 2'd3);
    end else begin
      baud_tick <= 1'b0;
    end
    if (baud_tick) tb_ticks <= tb_ticks + 1;
  end

  uart_32_bit_rx dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // strobe monitor
  int          valid_cnt = 0;
  int          ferr_cnt = 0;
  int          valid_tick = 0;
  int          prev_valid_tick = 0;
  int          ferr_tick = 0;
  logic [31:0] valid_data = 32'h0;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid === 1'b1) begin
        valid_cnt++;
        prev_valid_tick = valid_tick;
        valid_tick = tb_ticks;
        valid_data = data;
      end
      if (frame_err === 1'b1) begin
        ferr_cnt++;
        ferr_tick = tb_ticks;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_tick();
    int n;
    n = 0;
    @(posedge clk);
    while (baud_tick !== 1'b1) begin
      n++;
      if (n > 50) begin
        failures++;
        $display("FAIL wait_tick: no baud_tick within 50 clocks");
        $fatal(1, "tick generator stalled");
      end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) wait_tick();
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [31:0] w, input logic stop, output int start_n);
    start_n = tb_ticks;
    send_bit(1'b0);
    for (int i = 0; i < 32; i++) send_bit(w[i]);
    send_bit(stop);
  endtask

  int n0, n1, vc, fc;
  logic [31:0] w;

  initial begin
    // reset
    tick_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_data", data, 32'h0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    idle_ticks(4);

    // good frame A5A55A5A
    send_frame(32'hA5A5_5A5A, 1'b1, n0);
    check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
    check("a5_data", valid_data, 32'hA5A5_5A5A);
    check("a5_valid_tick", 32'(valid_tick), 32'(n0 + 537));
    check("a5_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("a5_busy", 32'(busy), 32'd0);
    idle_ticks(8);

    // false start: low 4 ticks then high
    rx = 1'b0;
    repeat (4) wait_tick();
    check("fs_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (8) wait_tick();
    check("fs_busy_lo", 32'(busy), 32'd0);
    check("fs_valid_cnt", 32'(valid_cnt), 32'd1);
    check("fs_ferr_cnt", 32'(ferr_cnt), 32'd0);
    send_frame(32'h1234_5678, 1'b1, n0);
    check("fs_next_cnt", 32'(valid_cnt), 32'd2);
    check("fs_next_data", data, 32'h1234_5678);
    idle_ticks(8);

    // framing error after a good 000000FF
    send_frame(32'h0000_00FF, 1'b1, n0);
    check("fe_good_data", data, 32'h0000_00FF);
    vc = valid_cnt;
    send_frame(32'hFFFF_FFFF, 1'b0, n0);
    check("fe_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("fe_ferr_tick", 32'(ferr_tick), 32'(n0 + 537));
    check("fe_no_valid", 32'(valid_cnt), 32'(vc));
    check("fe_data_hold", data, 32'h0000_00FF);
    idle_ticks(20);
    check("fe_busy_lo", 32'(busy), 32'd0);
    check("fe_ferr_once", 32'(ferr_cnt), 32'd1);

    // back-to-back frames, no idle gap
    vc = valid_cnt;
    send_frame(32'h0000_0001, 1'b1, n0);
    check("b2b_first", valid_data, 32'h0000_0001);
    send_frame(32'h8000_0000, 1'b1, n1);
    check("b2b_cnt", 32'(valid_cnt), 32'(vc + 2));
    check("b2b_second", valid_data, 32'h8000_0000);
    check("b2b_spacing", 32'(valid_tick - prev_valid_tick), 32'd544);
    idle_ticks(8);

    // reset during data bit 12
    vc = valid_cnt;
    fc = ferr_cnt;
    w = 32'h0F0F_0F0F;
    send_bit(1'b0);
    for (int i = 0; i < 12; i++) send_bit(w[i]);
    rx = w[12];
    repeat (8) wait_tick();
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_data", data, 32'h0);
    check("mr_valid", 32'(valid), 32'd0);
    check("mr_ferr", 32'(frame_err), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    idle_ticks(40);
    check("mr_no_strobe", 32'(valid_cnt + ferr_cnt), 32'(vc + fc));
    send_frame(32'hDEAD_BEEF, 1'b1, n0);
    check("mr_next_data", data, 32'hDEAD_BEEF);
    check("mr_next_cnt", 32'(valid_cnt), 32'(vc + 1));
    idle_ticks(8);

    // baud_tick frozen for 100 clocks mid-frame
    vc = valid_cnt;
    w = 32'h1357_9BDF;
    send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
    rx = w[10];
    repeat (5) wait_tick();
    tick_en = 1'b0;
    @(negedge clk);
    check("frz_state_a", 32'(dbg_state), 32'd2);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("frz_state_b", 32'(dbg_state), 32'd2);
    check("frz_busy", 32'(busy), 32'd1);
    check("frz_no_valid", 32'(valid_cnt), 32'(vc));
    tick_en = 1'b1;
    repeat (11) wait_tick();
    for (int i = 11; i < 32; i++) send_bit(w[i]);
    send_bit(1'b1);
    check("frz_data", data, 32'h1357_9BDF);
    check("frz_cnt", 32'(valid_cnt), 32'(vc + 1));
    idle_ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_32_bit_rx.md
# uart_32_bit_rx

Receiver for the 32-bit UART link: recovers frames of 1 start bit, 32 data bits (LSB first) and 1 stop bit from the serial line. Each bit is 16 `baud_tick` periods long, matching `uart_32_bit_tx`. The block samples each bit at mid-bit using 16x oversampling, presents the received word with a one-cycle `valid` strobe, and flags bad stop bits. It sits directly downstream of the serial line driven by `uart_32_bit_tx` and shares the same `baud_tick` source.

## Interface
- `OVERSAMPLE`, 16, baud_tick periods per bit
- `DATA_BITS`, 32, payload bits per frame
- `SYNC_STAGES`, 2, flops in the rx input synchronizer
- `clk` input 1: system clock
- `rst` input 1: reset, synchronous, active-high
- `baud_tick` input 1: single-cycle enable pulse at 16x baud rate
- `rx` input 1: asynchronous serial line, idle high
- `data` output 32: last correctly framed word; holds until the next good frame
- `valid` output 1: one-cycle pulse when `data` updates
- `frame_err` output 1: one-cycle pulse when the stop bit samples 0
- `busy` output 1: high in every state except IDLE

## Operation
- The `rx` input passes through the `SYNC_STAGES` synchronizer; the result is `rx_s`. Synchronizer flops reset to 1.
- Counters:
  - `tick_cnt` is 4 bits and wraps at 15.
  - `bit_cnt` is 5 bits, counting 0..31.
  - The shift register is 32 bits. Each sampled bit enters at bit 31 and the register shifts right, so bit 0 ends up as the first-received bit.
- State and counter updates happen only on cycles where `baud_tick=1`. With no tick, all state, counters and outputs hold, except that `valid` and `frame_err` deassert.
- IDLE:
  - On a tick with `rx_s=0`, go to START with `tick_cnt=0`.
- START:
  - On each tick where `tick_cnt!=7`, increment `tick_cnt`.
  - On the tick where `tick_cnt==7` (mid start bit): if `rx_s=0`, go to DATA with `tick_cnt=0` and `bit_cnt=0`. If `rx_s=1`, this is a false start: return to IDLE with no output.
- DATA:
  - On the tick where `tick_cnt==15`: shift in `rx_s` and set `tick_cnt=0`. If `bit_cnt==31`, go to STOP; otherwise increment `bit_cnt`.
  - On all other ticks, increment `tick_cnt`.
- STOP:
  - On the tick where `tick_cnt==15`: if `rx_s=1`, load `data` from the shift register and pulse `valid`. If `rx_s=0`, pulse `frame_err` and leave `data` unchanged.
  - In both cases return to IDLE. IDLE is reached at mid stop bit, so a start edge immediately following the stop bit is caught.
- Any illegal state encoding goes to IDLE on the next clock.
- Falling edges on `rx` while `busy=1` have no effect beyond normal sampling.
- Reset mid-frame:
  - state goes to IDLE and all counters clear
  - `data`=0, `valid`=0, `frame_err`=0, `busy`=0 on the cycle after `rst` is sampled high
  - the partial frame is discarded with no strobe

## Timing
- Reset values: `data`=32'h0, `valid`=0, `frame_err`=0, `busy`=0, state IDLE.
- Tick numbering: T0 is the tick that detects the start. Start is detected on the first tick after the synchronized falling edge, adding up to 1 tick plus `SYNC_STAGES` clocks of latency.
- Sample points:
  - start bit verified at T8
  - data bit i sampled at T8+16·(i+1)
  - stop bit sampled at T536
- `valid`/`frame_err` assert in the clk cycle after the T536 tick edge and last exactly one cycle. `data` is stable from that same cycle.
- `busy` rises the cycle after T0 and falls the cycle after the T536 or false-start tick.
- Back-to-back frames (no idle gap) are received continuously, one word per 544 ticks.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, STOP)
  - `UART_OVERSAMPLE`=16, `UART_DATA_BITS`=32, `UART_MID_TICK`=7
- One sub-module, `uart_rx_sync`: a parameterized `SYNC_STAGES` flop chain, reset to 1.
- Everything else lives in `uart_32_bit_rx`: the FSM, counters and shift register.

## Test plan
- Frame 32'hA5A5_5A5A with a good stop bit: one `valid` pulse at T536+1, `data`=32'hA5A55A5A, `frame_err` stays 0, `busy` drops.
- `rx` low for 4 ticks then high: no `valid`/`frame_err`, return to IDLE at T8, `busy` low afterwards, a following frame of 32'h1234_5678 is received correctly.
- Frame 32'hFFFF_FFFF with stop bit forced 0, after a prior good 32'h0000_00FF: one `frame_err` pulse, no `valid`, `data` remains 32'h000000FF.
- Back-to-back frames 32'h0000_0001 then 32'h8000_0000 with no idle gap: two `valid` pulses 544 ticks apart with the correct words.
- `rst` asserted during data bit 12 of a frame: all outputs reset next cycle, no strobe; the subsequent frame 32'hDEAD_BEEF yields `data`=32'hDEADBEEF.
- `baud_tick` held low for 100 clocks mid-frame: state and counters frozen; reception completes correctly once ticks resume.
